// File: rtl/nibble_tx_sched_pkg.sv
// Shared types and default sizing for the nibble transmit scheduler.
package nibble_tx_sched_pkg;

   localparam int unsigned DW_DEF          = 4;
   localparam int unsigned TIMEOUT_CYC_DEF = 64;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/nibble_tx_sched_rr2_pick.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr2_pick (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic win_c,
   output logic valid_c
);

   // Winner index and any-request flag, purely combinational.
   always_comb begin
      win_c   = 1'b0;
      valid_c = req0 | req1;
      if (req0 && req1) begin
         win_c = ~last;
      end else if (req1) begin
         win_c = 1'b1;
      end
   end

endmodule

// File: rtl/nibble_tx_sched.sv
// Arbitrates two word requesters onto one serializer with start/ack handshake
// and an ack timeout.
module nibble_tx_sched
   import nibble_tx_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned DW          = DW_DEF
) (
   input  logic          sclk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] Data,
   output logic          start,
   input  logic          ack,
   output logic          busy,
   output logic          timeout_err
);

   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ack_q;
   logic          ack_rise;
   logic          last, last_n;
   logic          win, win_n;
   logic [DW-1:0] data_n;
   logic          start_n, gnt0_n, gnt1_n, busy_n, tmo_n;
   logic          pick_win_c, pick_valid_c;

   rr2_pick u_pick (
      .req0    (req0),
      .req1    (req1),
      .last    (last),
      .win_c   (pick_win_c),
      .valid_c (pick_valid_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      last_n   = last;
      win_n    = win;
      data_n   = Data;
      start_n  = 1'b0;
      gnt0_n   = 1'b0;
      gnt1_n   = 1'b0;
      tmo_n    = 1'b0;
      ack_rise = ack & ~ack_q;

      case (state)
         IDLE: begin
            if (pick_valid_c) begin
               win_n   = pick_win_c;
               data_n  = pick_win_c ? din1 : din0;
               start_n = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: begin
            cnt_n   = '0;
            state_n = WAIT_ACK;
         end
         WAIT_ACK: begin
            // A rise in the final window cycle still completes the transfer.
            if (ack_rise) begin
               state_n = DONE;
            end else if (cnt == CNT_LAST) begin
               tmo_n   = 1'b1;
               last_n  = win;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DONE: begin
            gnt0_n  = ~win;
            gnt1_n  = win;
            last_n  = win;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   // State, counter, ack history and registered outputs.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ack_q       <= 1'b0;
         last        <= 1'b1;
         win         <= 1'b0;
         Data        <= '0;
         start       <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ack_q       <= ack;
         last        <= last_n;
         win         <= win_n;
         Data        <= data_n;
         start       <= start_n;
         gnt0        <= gnt0_n;
         gnt1        <= gnt1_n;
         busy        <= busy_n;
         timeout_err <= tmo_n;
      end
   end

endmodule
